roach_reset_sequencer: RTL and testbench
========================================

# roach_reset_sequencer

- Parametrised power-on and lock-driven reset sequencer for the ROACH2 infrastructure layer.
- Runs in the sys_clk domain.
- Holds power-on reset, then waits for N filtered clock-generator lock inputs, then runs the IDELAYCTRL reset/ready handshake with timeout and retry.
- After that it releases N_STAGE downstream reset domains in a staggered order, and re-sequences on lock loss or soft reset.

## Interface
- N_LOCK, 2: number of lock inputs (MMCM/PLL locks).
- N_STAGE, 3: number of staged reset outputs.
- POR_CYCLES, 4096: power-on hold length, in cycles.
- LOCK_FILTER, 8: number of consecutive all-locked cycles required.
- IDELAY_RST_CYCLES, 16: idelay_rst pulse width.
- IDELAY_TIMEOUT, 65535: cycles to wait for idelay_rdy before a retry.
- STAGE_GAP, 64: cycles between successive stage releases.
- sys_clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- lock_in  in  N_LOCK  asynchronous lock flags; 2-flop synchronised internally.
- lock_mask  in  N_LOCK  1 = lock bit is monitored; quasi-static, used unsynchronised.
- idelay_rdy  in  1  asynchronous; 2-flop synchronised internally.
- soft_rst  in  1  synchronous request pulse to re-sequence.
- op_power_on_rst  out  1  high during POR only.
- idelay_rst  out  1  IDELAYCTRL reset.
- stage_rst  out  N_STAGE  per-domain resets; bit 0 is released first.
- all_locked  out  1  high only in RUN.
- state  out  3  current state encoding.
- lock_loss_cnt  out  8  saturating count of lock-loss events.
- timeout_err  out  1  sticky; set on any idelay_rdy timeout.

## Operation
- States and encodings: POR=0, WAIT_LOCK=1, IDELAY_RST=2, IDELAY_WAIT=3, RELEASE=4, RUN=5.
- One shared cycle counter.
  - Width is clog2(max(POR_CYCLES, IDELAY_TIMEOUT, (N_STAGE-1)*STAGE_GAP, LOCK_FILTER)+1).
  - The counter clears on every state entry.
- ok = &(lock_sync | ~lock_mask). An all-zero mask therefore counts as locked.
- POR: op_power_on_rst=1, stage_rst all ones. When the counter reaches POR_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - The filter counter increments while ok is high and clears whenever ok is low.
  - When the filter reaches LOCK_FILTER, go to IDELAY_RST.
- IDELAY_RST: idelay_rst=1 for exactly IDELAY_RST_CYCLES cycles, then go to IDELAY_WAIT.
- IDELAY_WAIT:
  - If rdy_sync=1, go to RELEASE.
  - Else, when the counter reaches IDELAY_TIMEOUT-1: set timeout_err and return to IDELAY_RST. Retries are unlimited.
- RELEASE:
  - stage_rst[k] clears on the cycle when the counter equals k*STAGE_GAP.
  - Cleared bits stay cleared.
  - After stage N_STAGE-1 clears, go to RUN.
- RUN: all_locked=1.
- Lock loss:
  - Trigger: ok=0 in IDELAY_RST, IDELAY_WAIT, RELEASE or RUN. There is no filter on loss.
  - Response:
    - stage_rst goes to all ones.
    - idelay_rst goes to 0.
    - all_locked goes to 0.
    - lock_loss_cnt increments, saturating at 255.
    - Next state is WAIT_LOCK.
- soft_rst:
  - In any state except POR: same response as lock loss, but lock_loss_cnt does not change.
  - In POR: ignored.
- Priority: sys_rst > lock loss > soft_rst > normal transition.
- sys_rst: everything returns to POR, and all counters and timeout_err clear.

## Timing
- Reset values:
  - state=0, op_power_on_rst=1, stage_rst all ones.
  - idelay_rst=0, all_locked=0, lock_loss_cnt=0, timeout_err=0.
- All outputs are registered and reflect the current state. No combinational path runs from any input to any output.
- Synchroniser latency: 2 cycles from lock_in or idelay_rdy to the internal _sync signal.
- op_power_on_rst falls exactly POR_CYCLES edges after the first edge that samples sys_rst=0.
- Once locks are stable from t=0, the minimum time to the all_locked rise is POR_CYCLES + LOCK_FILTER + IDELAY_RST_CYCLES + (N_STAGE-1)*STAGE_GAP + sync/entry overhead.
  - Entry overhead is 1 cycle per state.
  - The bench checks exact edges against the RTL model.
- A lock-loss response appears 1 cycle after ok is sampled low, i.e. 3 cycles after the lock_in fall.
- A lock drop inside WAIT_LOCK only clears the filter. No count is recorded.
- Simultaneous lock loss and soft_rst: counted as a lock loss (count increments once).
- sys_rst asserted mid-RELEASE: the next cycle shows reset values. Partially released stages reassert.

## Test plan
Bench parameters: N_LOCK=2, N_STAGE=3, POR_CYCLES=16, LOCK_FILTER=4, IDELAY_RST_CYCLES=4, IDELAY_TIMEOUT=32, STAGE_GAP=8.

1. Nominal run:
   - Stimulus: locks high; idelay_rdy rises 5 cycles after idelay_rst falls.
   - Required: op_power_on_rst falls at cycle 16; idelay_rst is high for exactly 4 cycles; stage_rst goes 111→110→100→000 at 8-cycle spacing; all_locked=1; state=5.
2. Lock glitch in WAIT_LOCK:
   - Stimulus: lock_in[1] drops for 1 cycle after 3 good cycles.
   - Required: the filter restarts; IDELAY_RST entry is delayed by that 3+1 cycles; lock_loss_cnt=0.
3. Timeout retry:
   - Stimulus: idelay_rdy held low.
   - Required: after 32 cycles in IDELAY_WAIT, timeout_err=1 and idelay_rst re-pulses for 4 cycles. When rdy is then given, RUN is reached and timeout_err stays 1.
4. Lock loss in RUN:
   - Stimulus: lock_in[0] falls.
   - Required: 3 cycles later stage_rst=111, all_locked=0, lock_loss_cnt=1, state=1. Repeating 300 times leaves lock_loss_cnt=255.
5. Mask and soft reset:
   - Stimulus: lock_mask=2'b01 with lock_in[1]=0.
   - Required: RUN is reached. Then soft_rst with a simultaneous lock_in[0] fall gives lock_loss_cnt +1 (one increment only).
6. Reset mid-RELEASE:
   - Stimulus: sys_rst while stage_rst=100.
   - Required: the next cycle shows stage_rst=111, state=0, op_power_on_rst=1, counters=0, timeout_err=0.

Source files
------------

// File: rtl/roach_reset_sequencer.sv
// Power-on and lock-driven reset sequencer: POR hold, lock filtering, IDELAYCTRL
// reset/ready handshake with timeout retry, then staggered downstream releases.
module roach_reset_sequencer #(
    parameter int N_LOCK            = 2,
    parameter int N_STAGE           = 3,
    parameter int POR_CYCLES        = 4096,
    parameter int LOCK_FILTER       = 8,
    parameter int IDELAY_RST_CYCLES = 16,
    parameter int IDELAY_TIMEOUT    = 65535,
    parameter int STAGE_GAP         = 64
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [N_LOCK-1:0]  lock_in,
    input  logic [N_LOCK-1:0]  lock_mask,
    input  logic               idelay_rdy,
    input  logic               soft_rst,
    output logic               op_power_on_rst,
    output logic               idelay_rst,
    output logic [N_STAGE-1:0] stage_rst,
    output logic               all_locked,
    output logic [2:0]         state,
    output logic [7:0]         lock_loss_cnt,
    output logic               timeout_err
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(POR_CYCLES, IDELAY_TIMEOUT),
                                  max2((N_STAGE - 1) * STAGE_GAP, LOCK_FILTER));
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] POR_LAST     = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] IRST_LAST    = CW'(IDELAY_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(IDELAY_TIMEOUT - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'((N_STAGE - 1) * STAGE_GAP);

    typedef enum logic [2:0] {
        ST_POR         = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_IDELAY_RST  = 3'd2,
        ST_IDELAY_WAIT = 3'd3,
        ST_RELEASE     = 3'd4,
        ST_RUN         = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_step_s, cnt_next_s;
    logic [N_LOCK-1:0]  lock_meta_r, lock_sync_r;
    logic               rdy_meta_r, rdy_sync_r;
    logic               ok_s, enter_s, monitored_s;
    logic               por_r, idelay_rst_r, all_locked_r;
    logic               timeout_err_r, timeout_err_s;
    logic [N_STAGE-1:0] stage_rst_r, stage_rst_s, stage_base_s;
    logic [7:0]         loss_cnt_r, loss_cnt_s;

    // Two-flop synchronisers for the asynchronous lock and ready flags
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lock_meta_r <= {N_LOCK{1'b0}};
            lock_sync_r <= {N_LOCK{1'b0}};
            rdy_meta_r  <= 1'b0;
            rdy_sync_r  <= 1'b0;
        end else begin
            lock_meta_r <= lock_in;
            lock_sync_r <= lock_meta_r;
            rdy_meta_r  <= idelay_rdy;
            rdy_sync_r  <= rdy_meta_r;
        end
    end

    // Next-state logic: lock loss beats soft reset beats the normal sequence
    always_comb begin
        ok_s          = &(lock_sync_r | ~lock_mask);
        monitored_s   = (state_r == ST_IDELAY_RST) || (state_r == ST_IDELAY_WAIT) ||
                        (state_r == ST_RELEASE)    || (state_r == ST_RUN);
        state_s       = state_r;
        enter_s       = 1'b0;
        cnt_step_s    = cnt_r + CW'(1);
        loss_cnt_s    = loss_cnt_r;
        timeout_err_s = timeout_err_r;
        if (monitored_s && !ok_s) begin
            state_s = ST_WAIT_LOCK;
            enter_s = 1'b1;
            if (loss_cnt_r != 8'hFF) begin
                loss_cnt_s = loss_cnt_r + 8'd1;
            end else begin
                loss_cnt_s = loss_cnt_r;
            end
        end else if (soft_rst && (state_r != ST_POR)) begin
            state_s = ST_WAIT_LOCK;
            enter_s = 1'b1;
        end else begin
            case (state_r)
                ST_POR: begin
                    if (cnt_r == POR_LAST) begin
                        state_s = ST_WAIT_LOCK;
                        enter_s = 1'b1;
                    end else begin
                        state_s = ST_POR;
                    end
                end
                ST_WAIT_LOCK: begin
                    // The shared counter doubles as the consecutive-lock filter
                    if (!ok_s) begin
                        cnt_step_s = {CW{1'b0}};
                    end else if (cnt_r == FILTER_LAST) begin
                        state_s = ST_IDELAY_RST;
                        enter_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_IDELAY_RST: begin
                    if (cnt_r == IRST_LAST) begin
                        state_s = ST_IDELAY_WAIT;
                        enter_s = 1'b1;
                    end else begin
                        state_s = ST_IDELAY_RST;
                    end
                end
                ST_IDELAY_WAIT: begin
                    if (rdy_sync_r) begin
                        state_s = ST_RELEASE;
                        enter_s = 1'b1;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_s       = ST_IDELAY_RST;
                        enter_s       = 1'b1;
                        timeout_err_s = 1'b1;
                    end else begin
                        state_s = ST_IDELAY_WAIT;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == RELEASE_LAST) begin
                        state_s = ST_RUN;
                        enter_s = 1'b1;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                ST_RUN: begin
                    cnt_step_s = cnt_r;
                end
                default: begin
                    state_s = ST_POR;
                    enter_s = 1'b1;
                end
            endcase
        end
    end

    assign cnt_next_s = enter_s ? {CW{1'b0}} : cnt_step_s;

    // Stage resets: bit k drops when the release counter hits k*STAGE_GAP
    always_comb begin
        stage_base_s = (state_r == ST_RELEASE) ? stage_rst_r : {N_STAGE{1'b1}};
        stage_rst_s  = {N_STAGE{1'b1}};
        case (state_s)
            ST_RELEASE: begin
                for (int k = 0; k < N_STAGE; k++) begin
                    if (cnt_next_s == CW'(k * STAGE_GAP)) begin
                        stage_rst_s[k] = 1'b0;
                    end else begin
                        stage_rst_s[k] = stage_base_s[k];
                    end
                end
            end
            ST_RUN:  stage_rst_s = {N_STAGE{1'b0}};
            default: stage_rst_s = {N_STAGE{1'b1}};
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r       <= ST_POR;
            cnt_r         <= {CW{1'b0}};
            por_r         <= 1'b1;
            idelay_rst_r  <= 1'b0;
            stage_rst_r   <= {N_STAGE{1'b1}};
            all_locked_r  <= 1'b0;
            loss_cnt_r    <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_next_s;
            por_r         <= (state_s == ST_POR);
            idelay_rst_r  <= (state_s == ST_IDELAY_RST);
            stage_rst_r   <= stage_rst_s;
            all_locked_r  <= (state_s == ST_RUN);
            loss_cnt_r    <= loss_cnt_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign op_power_on_rst = por_r;
    assign idelay_rst      = idelay_rst_r;
    assign stage_rst       = stage_rst_r;
    assign all_locked      = all_locked_r;
    assign state           = state_r;
    assign lock_loss_cnt   = loss_cnt_r;
    assign timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_roach_reset_sequencer.sv
// Directed self-checking bench for roach_reset_sequencer with small parameters;
// inputs change and outputs are sampled on the falling clock edge.
module tb_roach_reset_sequencer;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] lock_in;
    logic [1:0] lock_mask;
    logic       idelay_rdy;
    logic       soft_rst;
    logic       op_power_on_rst;
    logic       idelay_rst;
    logic [2:0] stage_rst;
    logic       all_locked;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    roach_reset_sequencer #(
        .N_LOCK(2), .N_STAGE(3), .POR_CYCLES(16), .LOCK_FILTER(4),
        .IDELAY_RST_CYCLES(4), .IDELAY_TIMEOUT(32), .STAGE_GAP(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .lock_in(lock_in), .lock_mask(lock_mask),
        .idelay_rdy(idelay_rdy), .soft_rst(soft_rst), .op_power_on_rst(op_power_on_rst),
        .idelay_rst(idelay_rst), .stage_rst(stage_rst), .all_locked(all_locked),
        .state(state), .lock_loss_cnt(lock_loss_cnt), .timeout_err(timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int max_cycles);
        int n;
        n = 0;
        while ((state != target) && (n < max_cycles)) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(state), 32'(target));
    endtask

    initial begin
        sys_rst    = 1'b1;
        lock_in    = 2'b11;
        lock_mask  = 2'b11;
        idelay_rdy = 1'b0;
        soft_rst   = 1'b0;
        step(3);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_por", 32'(op_power_on_rst), 32'd1);
        check_eq("rst_stage", 32'(stage_rst), 32'h7);
        check_eq("rst_idelay", 32'(idelay_rst), 32'd0);
        check_eq("rst_locked", 32'(all_locked), 32'd0);
        check_eq("rst_loss", 32'(lock_loss_cnt), 32'd0);
        check_eq("rst_tmo", 32'(timeout_err), 32'd0);

        // Nominal run
        sys_rst = 1'b0;
        step(15);
        check_eq("por_hold", 32'(op_power_on_rst), 32'd1);
        step(1);
        check_eq("por_fall", 32'(op_power_on_rst), 32'd0);
        check_eq("wait_lock", 32'(state), 32'd1);
        step(3);
        check_eq("filter_run", 32'(state), 32'd1);
        step(1);
        check_eq("irst_enter", 32'(state), 32'd2);
        check_eq("irst_high", 32'(idelay_rst), 32'd1);
        step(3);
        check_eq("irst_last", 32'(idelay_rst), 32'd1);
        step(1);
        check_eq("irst_fall", 32'(idelay_rst), 32'd0);
        check_eq("iwait_enter", 32'(state), 32'd3);
        step(4);
        idelay_rdy = 1'b1;
        step(2);
        check_eq("rdy_sync_lat", 32'(state), 32'd3);
        step(1);
        check_eq("rel_enter", 32'(state), 32'd4);
        check_eq("stage_110", 32'(stage_rst), 32'h6);
        step(7);
        check_eq("stage_110_hold", 32'(stage_rst), 32'h6);
        step(1);
        check_eq("stage_100", 32'(stage_rst), 32'h4);
        step(7);
        check_eq("stage_100_hold", 32'(stage_rst), 32'h4);
        step(1);
        check_eq("stage_000", 32'(stage_rst), 32'h0);
        check_eq("rel_last", 32'(all_locked), 32'd0);
        step(1);
        check_eq("run_state", 32'(state), 32'd5);
        check_eq("run_locked", 32'(all_locked), 32'd1);

        // Lock loss in RUN, then saturation of the loss counter
        step(2);
        lock_in = 2'b10;
        step(2);
        check_eq("loss_lat_state", 32'(state), 32'd5);
        check_eq("loss_lat_locked", 32'(all_locked), 32'd1);
        step(1);
        check_eq("loss_stage", 32'(stage_rst), 32'h7);
        check_eq("loss_locked", 32'(all_locked), 32'd0);
        check_eq("loss_cnt1", 32'(lock_loss_cnt), 32'd1);
        check_eq("loss_state", 32'(state), 32'd1);
        for (int i = 0; i < 299; i++) begin
            lock_in = 2'b11;
            wait_state("relock", 3'd2, 20);
            lock_in = 2'b10;
            wait_state("reloss", 3'd1, 10);
        end
        check_eq("loss_sat", 32'(lock_loss_cnt), 32'd255);

        // Masked lock and soft reset coinciding with lock loss
        sys_rst   = 1'b1;
        lock_mask = 2'b01;
        lock_in   = 2'b01;
        idelay_rdy = 1'b1;
        step(2);
        sys_rst = 1'b0;
        wait_state("mask_run", 3'd5, 100);
        check_eq("mask_locked", 32'(all_locked), 32'd1);
        check_eq("mask_loss0", 32'(lock_loss_cnt), 32'd0);
        lock_in = 2'b00;
        step(2);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check_eq("both_cnt", 32'(lock_loss_cnt), 32'd1);
        check_eq("both_state", 32'(state), 32'd1);
        check_eq("both_stage", 32'(stage_rst), 32'h7);
        step(3);
        check_eq("both_cnt_hold", 32'(lock_loss_cnt), 32'd1);
        lock_in = 2'b01;
        wait_state("soft_rerun", 3'd5, 60);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check_eq("soft_state", 32'(state), 32'd1);
        check_eq("soft_stage", 32'(stage_rst), 32'h7);
        check_eq("soft_cnt", 32'(lock_loss_cnt), 32'd1);

        // Lock glitch in WAIT_LOCK and idelay_rdy timeout retry
        sys_rst    = 1'b1;
        lock_mask  = 2'b11;
        lock_in    = 2'b11;
        idelay_rdy = 1'b0;
        step(2);
        sys_rst = 1'b0;
        step(16);
        check_eq("g_wait", 32'(state), 32'd1);
        step(1);
        lock_in = 2'b01;
        step(1);
        lock_in = 2'b11;
        step(2);
        check_eq("g_restart", 32'(state), 32'd1);
        step(3);
        check_eq("g_delay", 32'(state), 32'd1);
        step(1);
        check_eq("g_irst", 32'(state), 32'd2);
        check_eq("g_loss0", 32'(lock_loss_cnt), 32'd0);
        step(4);
        check_eq("t_iwait", 32'(state), 32'd3);
        step(31);
        check_eq("t_before", 32'(timeout_err), 32'd0);
        check_eq("t_before_st", 32'(state), 32'd3);
        step(1);
        check_eq("t_err", 32'(timeout_err), 32'd1);
        check_eq("t_retry_st", 32'(state), 32'd2);
        check_eq("t_retry_irst", 32'(idelay_rst), 32'd1);
        step(3);
        check_eq("t_irst_last", 32'(idelay_rst), 32'd1);
        step(1);
        check_eq("t_irst_fall", 32'(idelay_rst), 32'd0);
        idelay_rdy = 1'b1;
        wait_state("t_run", 3'd5, 40);
        check_eq("t_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-RELEASE
        lock_in = 2'b10;
        step(3);
        check_eq("r_loss", 32'(lock_loss_cnt), 32'd1);
        lock_in = 2'b11;
        wait_state("r_release", 3'd4, 40);
        check_eq("r_stage_110", 32'(stage_rst), 32'h6);
        step(8);
        check_eq("r_stage_100", 32'(stage_rst), 32'h4);
        sys_rst = 1'b1;
        step(1);
        check_eq("r_stage", 32'(stage_rst), 32'h7);
        check_eq("r_state", 32'(state), 32'd0);
        check_eq("r_por", 32'(op_power_on_rst), 32'd1);
        check_eq("r_cnt", 32'(lock_loss_cnt), 32'd0);
        check_eq("r_tmo", 32'(timeout_err), 32'd0);
        check_eq("r_locked", 32'(all_locked), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
